shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; these and all other ports are listed below.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 A  input  32  rs1 operand.
REQ-007 B  input  32  rs2 operand; shamt source for R-type.
REQ-008 imm  input  32  immediate; imm[4:0] is shamt and imm[11:5] is the qualifier for I-type.
REQ-009 opcode / func3 / func7  input  7 / 3 / 7  instruction fields [6:0], [14:12], [31:25].
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  32  shift result.
REQ-013 illegal  output  1  request was not a legal shift encoding; qualified by out_valid.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept occurs when in_valid && in_ready at a clock edge; on accept the block SHALL register A, decoded op (SLL/SRL/SRA), shamt and illegal.
REQ-017 Decode SHALL be as follows:
- R-type opcode 0110011: shamt=B[4:0].
- I-type opcode 0010011: shamt=imm[4:0], qualifier imm[11:5].
- func3=001 with qualifier 0000000 → SLL.
- func3=101 with qualifier 0000000 → SRL.
- func3=101 with qualifier 0100000 → SRA.
- Every other combination → illegal.
REQ-018 From IDLE on accept, the next state SHALL be DONE if illegal or shamt==0, else SHIFT.
REQ-019 In each SHIFT cycle the block SHALL shift the working register by step=min(rem,8) and set rem=rem-step; the next state SHALL be DONE when rem reaches 0.
REQ-020 SLL and SRL SHALL fill with zeros; SRA SHALL replicate the working register's bit 31 each step.
REQ-021 The SHIFT phase SHALL last ceil(shamt/8) cycles, and out_valid SHALL assert 1+ceil(shamt/8) cycles after the accept edge.
REQ-022 With shamt==0 the result SHALL equal A, and out_valid SHALL assert 1 cycle after accept.
REQ-023 An illegal request SHALL give result=0 and illegal=1; a legal request SHALL give illegal=0.
REQ-024 In DONE, result and illegal SHALL hold stable until out_valid && out_ready, then the next state SHALL be IDLE.
REQ-025 There SHALL be no accept in the DONE-exit cycle; the next accept is possible one cycle later.
REQ-026 in_valid during SHIFT or DONE SHALL be ignored, because in_ready=0 there.
REQ-027 Input operands SHALL NOT be sampled except at accept; input changes after accept SHALL NOT affect the result.

Reset
REQ-028 When rst_n=0 the block SHALL immediately enter IDLE with in_ready=1, out_valid=0, result=0, illegal=0 and the internal rem/working register cleared.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation and discard the result; no out_valid SHALL follow.

Structure
REQ-030 A shared package SHALL hold:
- opcode constants OPCODE_R and OPCODE_I;
- func3 constants 001 and 101;
- qualifier constants 0000000 and 0100000;
- the shift-op enum (SLL/SRL/SRA);
- the state enum;
- step width constant 8.
REQ-031 The block SHALL contain one combinational sub-module, shift_decode, taking opcode/func3/func7/B/imm and producing op, shamt and illegal; the FSM, counter and datapath SHALL stay in shift_seq_ctrl.

Verification
REQ-032 SLL R-type, A=0x00000005, B=2 → result 0x00000014, illegal=0, out_valid 2 cycles after accept.
REQ-033 SRAI, A=0xFFFFF000, imm=0x00000404 → result 0xFFFFFF00, out_valid 2 cycles after accept.
REQ-034 SRL R-type, A=0x80000000, B=31 → 4 SHIFT cycles (8,8,8,7), result 0x00000001, out_valid 5 cycles after accept; SRA with the same operands → 0xFFFFFFFF.
REQ-035 SLLI, imm=0, A=0xDEADBEEF → result 0xDEADBEEF 1 cycle after accept; R-type, func3=001, func7=0100000 → result 0, illegal=1.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE → result, illegal and out_valid stable, in_ready=0; a back-to-back second request is accepted one cycle after the handshake.
REQ-037 Reset pulse during SHIFT of a shamt=31 request → IDLE immediately, in_ready=1, out_valid never asserts; a subsequent request completes correctly.

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared constants and types for the sequential shifter controller.
package shift_seq_ctrl_pkg;

    // Instruction encodings recognised by the decoder
    localparam logic [6:0] OPCODE_R   = 7'b0110011;
    localparam logic [6:0] OPCODE_I   = 7'b0010011;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [6:0] QUAL_BASE  = 7'b0000000;
    localparam logic [6:0] QUAL_ALT   = 7'b0100000;

    // Largest shift distance applied in one SHIFT cycle
    localparam logic [4:0] STEP_WIDTH = 5'd8;

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_decode.sv
// Combinational decode of a shift instruction into op, distance and legality.
module shift_decode
    import shift_seq_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] B,
    input  logic [31:0] imm,
    output shift_op_t   op,
    output logic [4:0]  shamt,
    output logic        illegal
);

    logic [6:0] qual;
    logic       known_opcode;

    // Only the low shamt bits and the qualifier field of the operands matter
    logic unused_bits;
    assign unused_bits = ^{B[31:5], imm[31:12]};

    // Pick shamt/qualifier source by format, then match func3 + qualifier
    always_comb begin
        op           = OP_SLL;
        shamt        = 5'd0;
        illegal      = 1'b1;
        qual         = 7'd0;
        known_opcode = 1'b0;
        if (opcode == OPCODE_R) begin
            known_opcode = 1'b1;
            shamt        = B[4:0];
            qual         = func7;
        end else if (opcode == OPCODE_I) begin
            known_opcode = 1'b1;
            shamt        = imm[4:0];
            qual         = imm[11:5];
        end
        if (known_opcode) begin
            if (func3 == F3_SLL && qual == QUAL_BASE) begin
                op      = OP_SLL;
                illegal = 1'b0;
            end else if (func3 == F3_SR && qual == QUAL_BASE) begin
                op      = OP_SRL;
                illegal = 1'b0;
            end else if (func3 == F3_SR && qual == QUAL_ALT) begin
                op      = OP_SRA;
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shifter: accepts one shift request, shifts up to 8 bits per
// cycle, then holds the result until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE and out_valid only in DONE, so the two never overlap
// and the earliest next accept is the cycle after the result transfer.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        illegal
);

    state_t      state, state_next;
    shift_op_t   op_q;
    logic [31:0] work_q;
    logic [4:0]  rem_q;
    logic        illegal_q;

    shift_op_t   dec_op;
    logic [4:0]  dec_shamt;
    logic        dec_illegal;

    logic        accept;
    logic [4:0]  step;
    logic [31:0] shifted;

    shift_decode u_decode (
        .opcode  (opcode),
        .func3   (func3),
        .func7   (func7),
        .B       (B),
        .imm     (imm),
        .op      (dec_op),
        .shamt   (dec_shamt),
        .illegal (dec_illegal)
    );

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (dec_illegal || dec_shamt == 5'd0)
                        state_next = ST_DONE;
                    else
                        state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_q <= STEP_WIDTH)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // One shift step: distance min(rem, 8); SRA refills from the current bit 31
    always_comb begin
        step    = (rem_q > STEP_WIDTH) ? STEP_WIDTH : rem_q;
        shifted = work_q;
        case (op_q)
            OP_SLL:  shifted = work_q << step;
            OP_SRL:  shifted = work_q >> step;
            OP_SRA:  shifted = $signed(work_q) >>> step;
            default: shifted = work_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Working register, remaining distance and captured decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q    <= 32'd0;
            rem_q     <= 5'd0;
            op_q      <= OP_SLL;
            illegal_q <= 1'b0;
        end else if (accept) begin
            // An illegal request reports a zero result and never shifts
            work_q    <= dec_illegal ? 32'd0 : A;
            rem_q     <= dec_illegal ? 5'd0 : dec_shamt;
            op_q      <= dec_op;
            illegal_q <= dec_illegal;
        end else if (state == ST_SHIFT) begin
            work_q <= shifted;
            rem_q  <= rem_q - step;
        end
    end

    assign result  = work_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl.
module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int n_cmp;
    int n_bad;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .imm       (imm),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a falling edge; it is accepted on the next rising
    // edge. Afterwards the operands are scrambled and in_valid stays high so
    // late sampling or a spurious accept would corrupt the result.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        @(negedge clk);
        opcode   = opc;
        func3    = f3;
        func7    = f7;
        A        = a;
        B        = b;
        imm      = im;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        A      = ~a;
        B      = ~b;
        imm    = ~im;
        func7  = ~f7;
        func3  = ~f3;
    endtask

    // Count falling edges after the accept edge until out_valid; -1 on timeout
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sll_r();
        int cyc;
        send(7'b0110011, 3'b001, 7'b0000000, 32'h0000_0005, 32'd2, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL sll_r_latency got %0d want 2", cyc); end
        n_cmp++; if (result !== 32'h0000_0014) begin n_bad++; $display("FAIL sll_r_result got %h want 00000014", result); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL sll_r_illegal got %b want 0", illegal); end
        handshake();
    endtask

    task automatic test_srai();
        int cyc;
        send(7'b0010011, 3'b101, 7'b0000000, 32'hFFFF_F000, 32'd0, 32'h0000_0404);
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL srai_latency got %0d want 2", cyc); end
        n_cmp++; if (result !== 32'hFFFF_FF00) begin n_bad++; $display("FAIL srai_result got %h want ffffff00", result); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL srai_illegal got %b want 0", illegal); end
        handshake();
    endtask

    task automatic test_long_shift();
        int cyc;
        send(7'b0110011, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL srl31_latency got %0d want 5", cyc); end
        n_cmp++; if (result !== 32'h0000_0001) begin n_bad++; $display("FAIL srl31_result got %h want 00000001", result); end
        handshake();
        send(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd31, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 5) begin n_bad++; $display("FAIL sra31_latency got %0d want 5", cyc); end
        n_cmp++; if (result !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sra31_result got %h want ffffffff", result); end
        handshake();
        // SLLI by 12: two steps (8,4)
        send(7'b0010011, 3'b001, 7'b0000000, 32'h0001_2345, 32'd0, 32'h0000_000C);
        wait_done(cyc);
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL slli12_latency got %0d want 3", cyc); end
        n_cmp++; if (result !== 32'h1234_5000) begin n_bad++; $display("FAIL slli12_result got %h want 12345000", result); end
        handshake();
    endtask

    task automatic test_zero_and_illegal();
        int cyc;
        send(7'b0010011, 3'b001, 7'b0000000, 32'hDEAD_BEEF, 32'd0, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL zero_latency got %0d want 1", cyc); end
        n_cmp++; if (result !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL zero_result got %h want deadbeef", result); end
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL zero_illegal got %b want 0", illegal); end
        handshake();
        send(7'b0110011, 3'b001, 7'b0100000, 32'h1234_5678, 32'd4, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL illegal_latency got %0d want 1", cyc); end
        n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL illegal_result got %h want 0", result); end
        n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal_flag got %b want 1", illegal); end
        handshake();
        // Unknown opcode with otherwise valid SRL fields
        send(7'b0110111, 3'b101, 7'b0000000, 32'hFFFF_FFFF, 32'd3, 32'd3);
        wait_done(cyc);
        n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL badopc_latency got %0d want 1", cyc); end
        n_cmp++; if (illegal !== 1'b1 || result !== 32'd0) begin
            n_bad++; $display("FAIL badopc_out got illegal=%b result=%h want 1/0", illegal, result);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int cyc;
        send(7'b0110011, 3'b001, 7'b0000000, 32'h0000_0001, 32'd3, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", cyc); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h0000_0008 || illegal !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] got v=%b r=%b res=%h ill=%b want 1/0/00000008/0",
                         i, out_valid, in_ready, result, illegal);
            end
        end
        // Release the result and present the next request in the same cycle
        out_ready = 1'b1;
        opcode    = 7'b0110011;
        func3     = 3'b101;
        func7     = 7'b0000000;
        A         = 32'hF000_0000;
        B         = 32'd4;
        imm       = 32'd0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_exit got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        A = 32'd0;
        B = 32'd0;
        wait_done(cyc);
        n_cmp++; if (cyc != 2) begin n_bad++; $display("FAIL b2b_latency got %0d want 2", cyc); end
        n_cmp++; if (result !== 32'h0F00_0000) begin n_bad++; $display("FAIL b2b_result got %h want 0f000000", result); end
        handshake();
    endtask

    task automatic test_reset_mid_shift();
        int cyc;
        int seen;
        send(7'b0110011, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0) begin
            n_bad++; $display("FAIL midrst_state got in_ready=%b out_valid=%b result=%h want 1/0/0",
                              in_ready, out_valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_valid got %0d want 0", seen); end
        send(7'b0110011, 3'b001, 7'b0000000, 32'h0000_0003, 32'd9, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL postrst_latency got %0d want 3", cyc); end
        n_cmp++; if (result !== 32'h0000_0600) begin n_bad++; $display("FAIL postrst_result got %h want 00000600", result); end
        handshake();
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = 32'd0;
        B         = 32'd0;
        imm       = 32'd0;
        opcode    = 7'd0;
        func3     = 3'd0;
        func7     = 7'd0;
        test_reset();
        test_sll_r();
        test_srai();
        test_long_shift();
        test_zero_and_illegal();
        test_back_to_back();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
